// File: rtl/sdes_stream_engine.sv
// S-DES engine over NBYTES bytes: 1-cycle key schedule, then 2 cycles per byte (RND1/RND2), byte 0 first.
// o_valid rises 1+2*NBYTES cycles after accept and holds until i_ready. Define SDES_CBC_EN for i_iv and CBC chaining.
module sdes_stream_engine #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          i_key,
  input  logic                i_mode,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [8*NBYTES-1:0] i_data,
`ifdef SDES_CBC_EN
  input  logic [7:0]          i_iv,
`endif
  output logic                o_valid,
  input  logic                i_ready,
  output logic [8*NBYTES-1:0] o_data
);

  localparam int            IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST   = IW'(NBYTES - 1);
  localparam logic [31:0]   S0_TBL = 32'hB7D81BB1;
  localparam logic [31:0]   S1_TBL = 32'hC613D2E4;

`ifdef SDES_CBC_EN
  localparam bit CBC = 1'b1;
  logic [7:0] iv_w;
  assign iv_w = i_iv;
`else
  localparam bit CBC = 1'b0;
  logic [7:0] iv_w;
  assign iv_w = 8'h00;
`endif

  typedef enum logic [2:0] {IDLE, KEYGEN, RND1, RND2, DONE} state_t;

  state_t              state_q;
  logic [9:0]          key_q;
  logic                mode_q;
  logic [8*NBYTES-1:0] data_q;
  logic [8*NBYTES-1:0] o_data_q;
  logic [7:0]          k1_q, k2_q, mid_q, chain_q;
  logic [IW-1:0]       idx_q;
  logic                o_valid_q, o_ready_q;

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [7:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  // Outer bits select the row, inner bits the column; entry i sits at bits [2i+1:2i].
  function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] b);
    return tbl[{b[3], b[0], b[2], b[1], 1'b0} +: 2];
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
    logic [7:0] t;
    logic [3:0] s;
    t = {x[0], x[3], x[2], x[1], x[2], x[1], x[0], x[3]} ^ sk;
    s = {sbox(S0_TBL, t[7:4]), sbox(S1_TBL, t[3:0])};
    return {x[7:4] ^ {s[2], s[0], s[1], s[3]}, x[3:0]};
  endfunction

  logic [9:0]          ks_p10, ks_ls1, ks_ls2;
  logic [7:0]          k1_d, k2_d, sk_a, sk_b;
  logic [7:0]          byte_in, mid_d, blk_d, out_d, chain_d;
  logic [8*NBYTES-1:0] res_d;

  assign ks_p10 = p10(key_q);
  assign ks_ls1 = {ks_p10[8:5], ks_p10[9], ks_p10[3:0], ks_p10[4]};
  assign ks_ls2 = {ks_ls1[7:5], ks_ls1[9:8], ks_ls1[2:0], ks_ls1[4:3]};
  assign k1_d   = p8(ks_ls1[7:0]);
  assign k2_d   = p8(ks_ls2[7:0]);
  assign sk_a   = mode_q ? k2_q : k1_q;
  assign sk_b   = mode_q ? k1_q : k2_q;

  // CBC: encrypt whitens the input byte, decrypt whitens the block output.
  always_comb begin
    byte_in = data_q[{idx_q, 3'b000} +: 8];
    mid_d   = fk(ip(byte_in ^ ((CBC && !mode_q) ? chain_q : 8'h00)), sk_a);
    blk_d   = ip_inv(fk({mid_q[3:0], mid_q[7:4]}, sk_b));
    out_d   = blk_d ^ ((CBC && mode_q) ? chain_q : 8'h00);
    chain_d = mode_q ? byte_in : out_d;
    res_d   = data_q;
    res_d[{idx_q, 3'b000} +: 8] = out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      mode_q    <= 1'b0;
      data_q    <= '0;
      o_data_q  <= '0;
      k1_q      <= '0;
      k2_q      <= '0;
      mid_q     <= '0;
      chain_q   <= '0;
      idx_q     <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid && o_ready_q) begin
            key_q     <= i_key;
            mode_q    <= i_mode;
            data_q    <= i_data;
            chain_q   <= iv_w;
            o_ready_q <= 1'b0;
            state_q   <= KEYGEN;
          end
        end
        KEYGEN: begin
          k1_q    <= k1_d;
          k2_q    <= k2_d;
          idx_q   <= '0;
          state_q <= RND1;
        end
        RND1: begin
          mid_q   <= mid_d;
          state_q <= RND2;
        end
        RND2: begin
          data_q  <= res_d;
          chain_q <= chain_d;
          if (idx_q == LAST) begin
            o_data_q  <= res_d;
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= RND1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = o_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule

// File: tb/tb_sdes_stream_engine.sv
// Bench for sdes_stream_engine: an NBYTES=4 instance for random traffic, an NBYTES=1 instance for the textbook vector.
module tb_sdes_stream_engine;

`ifdef SDES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  key4, key1;
  logic        mode4, mode1, vld4, vld1, rdy4, rdy1, ov4, ov1, ir4, ir1;
  logic [31:0] din4, dout4;
  logic [7:0]  din1, dout1;
  logic [7:0]  iv4, iv1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sdes_stream_engine #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .i_key(key4), .i_mode(mode4), .i_valid(vld4), .o_ready(rdy4),
    .i_data(din4),
`ifdef SDES_CBC_EN
    .i_iv(iv4),
`endif
    .o_valid(ov4), .i_ready(ir4), .o_data(dout4));

  sdes_stream_engine #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .i_key(key1), .i_mode(mode1), .i_valid(vld1), .o_ready(rdy1),
    .i_data(din1),
`ifdef SDES_CBC_EN
    .i_iv(iv1),
`endif
    .o_valid(ov1), .i_ready(ir1), .o_data(dout1));

  // Reference model: permutations as 1-based position tables, S-boxes as row/column arrays.
  typedef int tbl_t [10];
  localparam tbl_t T_P10 = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam tbl_t T_P8  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  localparam tbl_t T_IP  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  localparam tbl_t T_IPI = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  localparam tbl_t T_EP  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  localparam tbl_t T_P4  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  localparam int S0T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic logic [9:0] perm(input logic [9:0] x, input int nin, input int nout, input tbl_t t);
    logic [9:0] y = '0;
    for (int i = 0; i < nout; i++) y[nout - 1 - i] = x[nin - t[i]];
    return y;
  endfunction

  function automatic logic [4:0] rot5(input logic [4:0] v, input int n);
    int vi = int'(v);
    return 5'(((vi << n) | (vi >> (5 - n))) & 31);
  endfunction

  function automatic logic [3:0] m_f(input logic [3:0] r, input logic [7:0] sk);
    logic [9:0] e;
    logic [7:0] t;
    int s0, s1;
    logic [9:0] q;
    e  = perm({6'b0, r}, 4, 8, T_EP);
    t  = e[7:0] ^ sk;
    s0 = S0T[2 * int'(t[7]) + int'(t[4])][2 * int'(t[6]) + int'(t[5])];
    s1 = S1T[2 * int'(t[3]) + int'(t[0])][2 * int'(t[2]) + int'(t[1])];
    q  = perm({6'b0, 2'(s0), 2'(s1)}, 4, 4, T_P4);
    return q[3:0];
  endfunction

  function automatic logic [7:0] m_block(input logic [9:0] k, input logic dec, input logic [7:0] x);
    logic [9:0] p, q;
    logic [4:0] l, r;
    logic [7:0] k1, k2, sa, sb, t;
    p  = perm(k, 10, 10, T_P10);
    l  = rot5(p[9:5], 1);
    r  = rot5(p[4:0], 1);
    q  = perm({l, r}, 10, 8, T_P8);
    k1 = q[7:0];
    q  = perm({rot5(l, 2), rot5(r, 2)}, 10, 8, T_P8);
    k2 = q[7:0];
    sa = dec ? k2 : k1;
    sb = dec ? k1 : k2;
    q  = perm({2'b0, x}, 8, 8, T_IP);
    t  = q[7:0];
    t  = {t[7:4] ^ m_f(t[3:0], sa), t[3:0]};
    t  = {t[3:0], t[7:4]};
    t  = {t[7:4] ^ m_f(t[3:0], sb), t[3:0]};
    q  = perm({2'b0, t}, 8, 8, T_IPI);
    return q[7:0];
  endfunction

  function automatic logic [31:0] m_stream(input logic [9:0] k, input logic dec, input logic [31:0] d,
                                           input logic [7:0] iv);
    logic [7:0]  prev = iv;
    logic [7:0]  b, o;
    logic [31:0] res = '0;
    for (int i = 0; i < 4; i++) begin
      b = d[8 * i +: 8];
      if (!dec) begin
        o    = m_block(k, 1'b0, CBC ? (b ^ prev) : b);
        prev = o;
      end else begin
        o    = m_block(k, 1'b1, b) ^ (CBC ? prev : 8'h00);
        prev = b;
      end
      res[8 * i +: 8] = o;
    end
    return res;
  endfunction

  // Stimulus helpers: present one request to the 4-byte engine (must be IDLE), wait for o_valid, consume.
  task automatic start4(input logic [9:0] k, input logic m, input logic [31:0] d, input logic [7:0] iv);
    key4 = k; mode4 = m; din4 = d; iv4 = iv; vld4 = 1'b1;
    @(posedge clk); #1;
    vld4 = 1'b0;
  endtask

  task automatic wait4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov4 && n < 200);
  endtask

  task automatic consume4();
    ir4 = 1'b1;
    @(posedge clk); #1;
    ir4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1 || dout4 !== 32'h0) begin
      errors++;
      $display("FAIL reset4: valid=%b ready=%b data=%h required 0 1 00000000", ov4, rdy4, dout4);
    end
    checks++;
    if (ov1 !== 1'b0 || rdy1 !== 1'b1 || dout1 !== 8'h0) begin
      errors++;
      $display("FAIL reset1: valid=%b ready=%b data=%h required 0 1 00", ov1, rdy1, dout1);
    end
    rst = 1'b0;
  endtask

  task automatic test_known_vector();
    logic [7:0] in_v [2];
    logic [7:0] exp_v [2];
    int n;
    in_v[0] = 8'b10010111; exp_v[0] = 8'b00111000;
    in_v[1] = 8'b00111000; exp_v[1] = 8'b10010111;
    for (int t = 0; t < 2; t++) begin
      key1 = 10'b1010000010; mode1 = 1'(t); din1 = in_v[t]; iv1 = 8'h00; vld1 = 1'b1;
      @(posedge clk); #1;
      vld1 = 1'b0;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ov1 && n < 50);
      checks++;
      if (n !== 3 || dout1 !== exp_v[t] || rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL known_vector%0d: latency=%0d data=%b ready=%b required 3 %b 0", t, n, dout1, rdy1, exp_v[t]);
      end
      ir1 = 1'b1;
      @(posedge clk); #1;
      ir1 = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [9:0]  k;
    logic        m;
    logic [31:0] d, exp_d, ct;
    logic [7:0]  iv;
    int n;
    for (int i = 0; i < 12; i++) begin
      k = 10'($urandom); m = 1'($urandom); d = $urandom; iv = 8'($urandom);
      exp_d = m_stream(k, m, d, iv);
      start4(k, m, d, iv);
      wait4(n);
      checks++;
      if (n !== 9 || dout4 !== exp_d || rdy4 !== 1'b0) begin
        errors++;
        $display("FAIL random%0d: latency=%0d data=%h ready=%b required 9 %h 0", i, n, dout4, rdy4, exp_d);
      end
      consume4();
      checks++;
      if (ov4 !== 1'b0 || rdy4 !== 1'b1) begin
        errors++;
        $display("FAIL random_release%0d: valid=%b ready=%b required 0 1", i, ov4, rdy4);
      end
    end
    k = 10'b1010000010; d = $urandom; iv = 8'($urandom);
    start4(k, 1'b0, d, iv);
    wait4(n);
    ct = dout4;
    consume4();
    start4(k, 1'b1, ct, iv);
    wait4(n);
    checks++;
    if (n !== 9 || dout4 !== d) begin
      errors++;
      $display("FAIL roundtrip: latency=%0d data=%h required 9 %h", n, dout4, d);
    end
    consume4();
  endtask

  task automatic test_backpressure();
    logic [9:0]  k = 10'($urandom);
    logic [31:0] d = $urandom;
    logic [7:0]  iv = 8'($urandom);
    logic [31:0] exp_d = m_stream(k, 1'b0, d, iv);
    int n;
    start4(k, 1'b0, d, iv);
    wait4(n);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ov4 !== 1'b1 || rdy4 !== 1'b0 || dout4 !== exp_d) begin
        errors++;
        $display("FAIL backpressure%0d: valid=%b ready=%b data=%h required 1 0 %h", c, ov4, rdy4, dout4, exp_d);
      end
      @(posedge clk); #1;
    end
    consume4();
    checks++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1 || dout4 !== exp_d) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b data=%h required 0 1 %h", ov4, rdy4, dout4, exp_d);
    end
    @(posedge clk); #1;
    checks++;
    if (dout4 !== exp_d) begin
      errors++;
      $display("FAIL idle_hold: data=%h required %h", dout4, exp_d);
    end
  endtask

  task automatic test_busy();
    logic [9:0]  k = 10'($urandom);
    logic [31:0] d = $urandom;
    logic [7:0]  iv = 8'($urandom);
    logic [31:0] exp_d = m_stream(k, 1'b0, d, iv);
    int n;
    start4(k, 1'b0, d, iv);
    key4 = ~k; mode4 = 1'b1; din4 = ~d; iv4 = ~iv; vld4 = 1'b1;
    wait4(n);
    vld4 = 1'b0;
    checks++;
    if (n !== 9 || dout4 !== exp_d) begin
      errors++;
      $display("FAIL busy: latency=%0d data=%h required 9 %h", n, dout4, exp_d);
    end
    consume4();
    @(posedge clk); #1;
    checks++;
    if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: ready=%b valid=%b required 1 0", rdy4, ov4);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0]  k = 10'($urandom);
    logic [31:0] d = $urandom;
    logic [7:0]  iv = 8'($urandom);
    logic [31:0] exp_d;
    int n, seen;
    start4(k, 1'b0, d, iv);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || rdy4 !== 1'b1 || dout4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b data=%h required 0 1 00000000", ov4, rdy4, dout4);
    end
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ov4 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_valid: valid cycles=%0d required 0", seen);
    end
    k = 10'($urandom); d = $urandom;
    exp_d = m_stream(k, 1'b1, d, iv);
    start4(k, 1'b1, d, iv);
    wait4(n);
    checks++;
    if (n !== 9 || dout4 !== exp_d) begin
      errors++;
      $display("FAIL after_reset: latency=%0d data=%h required 9 %h", n, dout4, exp_d);
    end
    consume4();
  endtask

  task automatic test_back_to_back();
    logic [9:0]  k = 10'($urandom);
    logic [31:0] d = $urandom;
    logic [7:0]  iv = 8'($urandom);
    logic [31:0] exp_d = m_stream(k, 1'b0, d, iv);
    int n;
    key4 = k; mode4 = 1'b0; din4 = d; iv4 = iv; vld4 = 1'b1; ir4 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov4 && n < 200);
    checks++;
    if (n !== 10 || dout4 !== exp_d) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d data=%h required 10 %h", n, dout4, exp_d);
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ov4 && n > 1) && n < 200);
    vld4 = 1'b0;
    checks++;
    if (n !== 11 || dout4 !== exp_d) begin
      errors++;
      $display("FAIL b2b_spacing: edges=%0d data=%h required 11 %h", n, dout4, exp_d);
    end
    @(posedge clk); #1;
    ir4 = 1'b0;
  endtask

`ifdef SDES_CBC_EN
  task automatic test_cbc();
    logic [9:0]  k = 10'($urandom);
    logic [31:0] exp_d;
    logic [7:0]  prev = 8'hA5;
    int n;
    for (int i = 0; i < 4; i++) begin
      prev = m_block(k, 1'b0, prev);
      exp_d[8 * i +: 8] = prev;
    end
    start4(k, 1'b0, 32'h0, 8'hA5);
    wait4(n);
    checks++;
    if (dout4 !== exp_d) begin
      errors++;
      $display("FAIL cbc_encrypt: data=%h required %h", dout4, exp_d);
    end
    consume4();
    start4(k, 1'b1, exp_d, 8'hA5);
    wait4(n);
    checks++;
    if (dout4 !== 32'h0) begin
      errors++;
      $display("FAIL cbc_decrypt: data=%h required 00000000", dout4);
    end
    consume4();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    key4 = '0; mode4 = 1'b0; vld4 = 1'b0; din4 = '0; iv4 = '0; ir4 = 1'b0;
    key1 = '0; mode1 = 1'b0; vld1 = 1'b0; din1 = '0; iv1 = '0; ir1 = 1'b0;
    test_reset();
    test_known_vector();
    test_random();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef SDES_CBC_EN
    test_cbc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
